// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between two requesters. Port 0 is the loader/DMA
// side, port 1 is the CPU data bus. Only one memory access is in flight at a
// time: the winner's address, data and direction are latched in IDLE, a
// single-cycle read or write strobe is issued, and the arbiter then waits for
// the memory to report ready again. A watchdog aborts accesses that hang in
// WAIT and reports them with an error flag alongside the done pulse.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  - defined: round-robin between the two ports.
//                         undefined: fixed priority, port 0 over port 1.
//
// Parameters:
//   TIMEOUT  max cycles in WAIT before the access is aborted (0 = no watchdog)
//   TO_W     watchdog counter width, 2**TO_W must exceed TIMEOUT
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_a/m0_d/m0_we/m0_rd    port 0 request (level, held until m0_done)
//   m0_spo/m0_done/m0_err    port 0 read data, completion pulse, timeout flag
//   m1_*                     same for port 1 (CPU)
//   a_mem/d_mem              memory address / write data (held between accesses)
//   we_mem/rd_mem            one-cycle memory write / read strobes
//   spo_mem/ready_mem        memory read data / memory idle-or-finished
//   busy                     a transaction is in progress
//   grant                    owner of the current or last transaction

module mem_port_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Watchdog fires on the TIMEOUT-th WAIT cycle, i.e. when the count that was
  // cleared in ISSUE has reached TIMEOUT-1.
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_r;
  state_t          state_next_s;
  logic            dir_r;          // 1 = write, 0 = read
  logic            first_wait_r;   // high during the first WAIT cycle
  logic [TO_W-1:0] wd_cnt_r;

  logic            req0_s;
  logic            req1_s;
  logic            win_s;          // winning port in IDLE
  logic            win_we_s;       // winner's direction (we wins over rd)
  logic            load_s;         // latch winner and issue strobe
  logic            finish_s;       // access ends this cycle
  logic            fin_err_s;      // ...because the watchdog expired

`ifdef ARB_ROUND_ROBIN_EN
  logic            last_grant_r;
`endif

  assign req0_s   = m0_we | m0_rd;
  assign req1_s   = m1_we | m1_rd;
  assign win_we_s = win_s ? m1_we : m0_we;

  // Arbitration: choose which pending port wins in IDLE.
  always_comb begin
    win_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req0_s && req1_s) begin
      win_s = ~last_grant_r;
    end else begin
      win_s = ~req0_s;
    end
`else
    if (req0_s) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`endif
  end

  // Next-state logic and per-cycle control strobes of the transaction FSM.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    finish_s     = 1'b0;
    fin_err_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ready_mem && (req0_s || req1_s)) begin
          load_s       = 1'b1;
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_next_s = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle gives the memory time to drop ready.
        if (ready_mem && !first_wait_r) begin
          finish_s     = 1'b1;
          state_next_s = S_DONE;
        end else if (TO_EN && (wd_cnt_r == TO_LAST)) begin
          finish_s     = 1'b1;
          fin_err_s    = 1'b1;
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register plus busy flag derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != S_IDLE);
    end
  end

  // Latch winner's request and drive the single-cycle memory strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mem  <= 32'd0;
      d_mem  <= 32'd0;
      dir_r  <= 1'b0;
      grant  <= 1'b0;
      we_mem <= 1'b0;
      rd_mem <= 1'b0;
    end else if (load_s) begin
      a_mem  <= win_s ? m1_a : m0_a;
      d_mem  <= win_s ? m1_d : m0_d;
      dir_r  <= win_we_s;
      grant  <= win_s;
      we_mem <= win_we_s;
      rd_mem <= ~win_we_s;
    end else begin
      we_mem <= 1'b0;
      rd_mem <= 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last winner so a tie goes to the other port next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if (load_s) begin
      last_grant_r <= win_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Watchdog counter and first-WAIT-cycle marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r     <= {TO_W{1'b0}};
      first_wait_r <= 1'b0;
    end else begin
      first_wait_r <= (state_r == S_ISSUE);
      if (state_r == S_ISSUE) begin
        wd_cnt_r <= {TO_W{1'b0}};
      end else if (state_r == S_WAIT) begin
        wd_cnt_r <= wd_cnt_r + TO_W'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end
  end

  // Completion: done/err pulses to the granted port, read data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      m0_spo  <= 32'd0;
      m1_spo  <= 32'd0;
    end else begin
      m0_done <= finish_s & ~grant;
      m1_done <= finish_s & grant;
      m0_err  <= fin_err_s & ~grant;
      m1_err  <= fin_err_s & grant;
      // Read data is only taken on a successful read; writes and timeouts
      // leave the requester's last read value in place.
      if (finish_s && !fin_err_s && !dir_r) begin
        if (grant) begin
          m1_spo <= spo_mem;
        end else begin
          m0_spo <= spo_mem;
        end
      end else begin
        m0_spo <= m0_spo;
        m1_spo <= m1_spo;
      end
    end
  end

endmodule
